// File: rtl/bw_io_impctl_sclk_gen.sv
// Purpose: programmable slow-clock generator for impctl; divides l2clk by N = div_sel+1 (N >= 2).
// Latency: sclk is registered; int_sclk is the combinational terminal-count tick one cycle ahead.
// Backpressure: none; enable=0 freezes the phase counter and forces sclk low.
//
// Ports:
//   l2clk        core clock, all flops on rising edge
//   global_reset synchronous active-high reset
//   enable       1 = count, 0 = hold count and force sclk low
//   div_sel      requested ratio minus 1 (0 is treated as 1)
//   mode         0 = one-cycle pulse per period, 1 = ~50% square
//   sync         restart phase and reload the ratio immediately
//   se, si, so   scan chain: si -> cnt[0] .. cnt[MSB] -> sclk flop -> so
//   int_sclk     terminal-count tick
//   sclk/ssclk_n divided clock and its complement
//   div_active   ratio currently in force, minus 1
module bw_io_impctl_sclk_gen #(
  parameter int CNT_W   = 4,
  parameter int DEF_DIV = 16
) (
  input  logic             l2clk,
  input  logic             global_reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_sel,
  input  logic             mode,
  input  logic             sync,
  input  logic             se,
  input  logic             si,
  output logic             so,
  output logic             int_sclk,
  output logic             sclk,
  output logic             ssclk_n,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [CNT_W-1:0] div_eff;
  logic             tc;
  logic [CNT_W:0]   hi_thr;

  // A ratio of 1 cannot toggle, so div_sel=0 is promoted to N=2.
  assign div_eff = (div_sel == '0) ? CNT_W'(1) : div_sel;
  assign tc      = (cnt_q == div_q);

  // Square mode is high for floor(N/2) of N cycles: the high phase starts at
  // cnt = N - floor(N/2) = ceil(N/2) = (div_q + 2) >> 1. One extra bit keeps
  // div_q = 2^CNT_W-1 from overflowing.
  assign hi_thr = ({1'b0, div_q} + (CNT_W+1)'(2)) >> 1;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    sclk_d = sclk_q;
    if (se) begin
      cnt_d  = {cnt_q[CNT_W-2:0], si};
      sclk_d = cnt_q[CNT_W-1];
    end else if (sync) begin
      cnt_d  = '0;
      div_d  = div_eff;
      sclk_d = 1'b0;
    end else if (!enable) begin
      sclk_d = 1'b0;
    end else begin
      // New ratio is adopted only at wrap so no period is ever cut short or
      // stretched. A scanned-in cnt above div_q just rolls over naturally.
      if (tc) begin
        cnt_d = '0;
        div_d = div_eff;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sclk_d = mode ? ({1'b0, cnt_q} >= hi_thr) : tc;
    end
  end

  always_ff @(posedge l2clk) begin
    if (global_reset) begin
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign int_sclk   = enable & tc & ~se;
  assign sclk       = sclk_q;
  assign ssclk_n    = ~sclk_q;
  assign so         = sclk_q;
  assign div_active = div_q;

endmodule
